// File: rtl/display_timing_gen.sv
// rtl/display_timing_gen.sv - parametrised raster timing generator with registered, aligned outputs
module display_timing_gen #(
   parameter int   CORDW  = 10,
   parameter int   H_RES  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_RES  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             pix_en,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             data_en,
   output logic             line,
   output logic             frame
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   if (CORDW < 1 || CORDW > 30 || (64'd1 << CORDW) < 64'(MAX_TOTAL)) begin : g_bad_cordw
      $error("display_timing_gen: CORDW too small for H_TOTAL/V_TOTAL");
   end
   if (H_RES < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_RES < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("display_timing_gen: every timing parameter must be >= 1");
   end

   // Decode boundaries, all fixed at elaboration.
   localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
   localparam logic [CORDW-1:0] HS_BEGIN = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
   localparam logic [CORDW-1:0] VS_BEGIN = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

   logic [CORDW-1:0] cx;
   logic [CORDW-1:0] cy;
   logic             h_wrap;
   logic             v_wrap;
   logic             active;
   logic             hs_active;
   logic             vs_active;

   always_comb begin
      h_wrap    = (cx == H_LAST);
      v_wrap    = (cy == V_LAST);
      active    = (cx < H_ACT) && (cy < V_ACT);
      hs_active = (cx >= HS_BEGIN) && (cx < HS_END);
      vs_active = (cy >= VS_BEGIN) && (cy < VS_END);
   end

   // Outputs present the decode of the counter value one enabled cycle later.
   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         cx      <= '0;
         cy      <= '0;
         sx      <= '0;
         sy      <= '0;
         hsync   <= !H_POL;
         vsync   <= !V_POL;
         data_en <= 1'b0;
         line    <= 1'b0;
         frame   <= 1'b0;
      end else begin
         line  <= 1'b0;
         frame <= 1'b0;
         if (pix_en) begin
            if (h_wrap) begin
               cx <= '0;
               cy <= v_wrap ? '0 : cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
            sx      <= cx;
            sy      <= cy;
            data_en <= active;
            hsync   <= hs_active ? H_POL : !H_POL;
            vsync   <= vs_active ? V_POL : !V_POL;
            line    <= (cx == '0);
            frame   <= (cx == '0) && (cy == '0);
         end
      end
   end

endmodule

// File: tb/tb_display_timing_gen.sv
// tb/tb_display_timing_gen.sv - directed self-checking bench for display_timing_gen (default and small modes)
module tb_display_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, rst_b, en_b;
   logic [9:0] sx_a, sy_a;
   logic       hs_a, vs_a, de_a, ln_a, fr_a;
   logic [3:0] sx_b, sy_b;
   logic       hs_b, vs_b, de_b, ln_b, fr_b;

   int checks = 0;
   int failures = 0;

   display_timing_gen dut_a (
      .clk_pix(clk), .rst_n(rst_a), .pix_en(en_a),
      .sx(sx_a), .sy(sy_a), .hsync(hs_a), .vsync(vs_a),
      .data_en(de_a), .line(ln_a), .frame(fr_a)
   );

   display_timing_gen #(
      .CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
   ) dut_b (
      .clk_pix(clk), .rst_n(rst_b), .pix_en(en_b),
      .sx(sx_b), .sy(sy_b), .hsync(hs_b), .vsync(vs_b),
      .data_en(de_b), .line(ln_b), .frame(fr_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int de_cnt, hs_cnt, ln_cnt, fr_cnt, first_hs, last_hs, bad;
      int ex, ey, nfr;
      int fr_at[3];
      logic [14:0] exp_b;
      logic [23:0] prev;

      rst_a = 1'b0; en_a = 1'b1;
      rst_b = 1'b0; en_b = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      // Reset values, default mode (active-low syncs idle high)
      chk("a_rst_sx", sx_a, 0);
      chk("a_rst_sy", sy_a, 0);
      chk("a_rst_hs", hs_a, 1);
      chk("a_rst_vs", vs_a, 1);
      chk("a_rst_de", de_a, 0);
      chk("a_rst_line", ln_a, 0);
      chk("a_rst_frame", fr_a, 0);

      // Three full lines starting from the release edge
      rst_a = 1'b1;
      de_cnt = 0; hs_cnt = 0; ln_cnt = 0; fr_cnt = 0; first_hs = -1; last_hs = -1;
      for (int i = 0; i < 2400; i++) begin
         tick();
         if (i == 0) begin
            chk("a_first_sx", sx_a, 0);
            chk("a_first_de", de_a, 1);
            chk("a_first_line", ln_a, 1);
            chk("a_first_frame", fr_a, 1);
            chk("a_first_hs", hs_a, 1);
         end
         if (de_a) de_cnt++;
         if (!hs_a) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = int'(sx_a);
            last_hs = int'(sx_a);
         end
         if (ln_a) ln_cnt++;
         if (fr_a) fr_cnt++;
      end
      chk("a_de_cnt", de_cnt, 1920);
      chk("a_hs_cnt", hs_cnt, 288);
      chk("a_first_hs_sx", first_hs, 656);
      chk("a_last_hs_sx", last_hs, 751);
      chk("a_line_cnt", ln_cnt, 3);
      chk("a_frame_cnt", fr_cnt, 1);
      chk("a_end_sx", sx_a, 799);
      chk("a_end_sy", sy_a, 2);

      // Hold mid-line at sx=100 for 1000 cycles
      for (int i = 0; i < 101; i++) tick();
      chk("a_pre_hold_sx", sx_a, 100);
      chk("a_pre_hold_sy", sy_a, 3);
      en_a = 1'b0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (sx_a != 10'd100 || sy_a != 10'd3 || !hs_a || !vs_a || !de_a || ln_a || fr_a) bad++;
      end
      chk("a_hold_bad", bad, 0);
      en_a = 1'b1;
      tick();
      chk("a_resume_sx", sx_a, 101);
      chk("a_resume_line", ln_a, 0);

      // pix_en toggling: 1600 clocks = 800 enabled cycles
      bad = 0; ln_cnt = 0;
      prev = {sx_a, sy_a, hs_a, vs_a, de_a, ln_a};
      for (int i = 0; i < 1600; i++) begin
         en_a = (i % 2 == 0);
         tick();
         if (i % 2 == 1) begin
            if ({sx_a, sy_a, hs_a, vs_a, de_a} != prev[23:1] || ln_a || fr_a) bad++;
         end
         if (ln_a) ln_cnt++;
         prev = {sx_a, sy_a, hs_a, vs_a, de_a, ln_a};
      end
      en_a = 1'b1;
      chk("a_toggle_hold_bad", bad, 0);
      chk("a_toggle_line_cnt", ln_cnt, 1);
      chk("a_toggle_sx", sx_a, 101);
      chk("a_toggle_sy", sy_a, 4);

      // Reset mid-line at sx=300 aborts the line
      for (int i = 0; i < 199; i++) tick();
      chk("a_pre_rst_sx", sx_a, 300);
      rst_a = 1'b0;
      tick();
      chk("a_midrst_sx", sx_a, 0);
      chk("a_midrst_sy", sy_a, 0);
      chk("a_midrst_de", de_a, 0);
      chk("a_midrst_hs", hs_a, 1);
      chk("a_midrst_line", ln_a, 0);
      rst_a = 1'b1;
      tick();
      chk("a_rel_sx", sx_a, 0);
      chk("a_rel_sy", sy_a, 0);
      chk("a_rel_frame", fr_a, 1);
      hs_cnt = 0; first_hs = -1;
      for (int i = 0; i < 799; i++) begin
         tick();
         if (!hs_a) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = int'(sx_a);
         end
      end
      chk("a_rel_hs_cnt", hs_cnt, 96);
      chk("a_rel_first_hs", first_hs, 656);

      // Small mode: active-high syncs idle low in reset
      chk("b_rst_hs", hs_b, 0);
      chk("b_rst_vs", vs_b, 0);
      chk("b_rst_de", de_b, 0);
      rst_b = 1'b1;
      ex = 0; ey = 0; nfr = 0;
      for (int i = 0; i < 294; i++) begin
         tick();
         exp_b = {4'(ex), 4'(ey),
                  (ex >= 10 && ex <= 12), (ey == 5),
                  (ex < 8 && ey < 4), (ex == 0), (ex == 0 && ey == 0)};
         chk($sformatf("b_cyc%0d", i), {sx_b, sy_b, hs_b, vs_b, de_b, ln_b, fr_b}, exp_b);
         if (fr_b && nfr < 3) begin
            fr_at[nfr] = i;
            nfr++;
         end
         if (i == 97) begin
            chk("b_last_sx", sx_b, 13);
            chk("b_last_sy", sy_b, 6);
         end
         if (ex == 13) begin
            ex = 0;
            ey = (ey == 6) ? 0 : ey + 1;
         end else begin
            ex = ex + 1;
         end
      end
      chk("b_frame_cnt", nfr, 3);
      if (nfr == 3) begin
         chk("b_frame_period0", fr_at[1] - fr_at[0], 98);
         chk("b_frame_period1", fr_at[2] - fr_at[1], 98);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
